// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ID/EX register, ALU, data SRAM request, iterative divider
//
// Ports:
//   clk, rst           pipeline clock, asynchronous active-low reset
//   stall[5:0]         stall vector; bit 2 holds ID/EX, bit 3 holds EX/MEM
//   id_to_ex_bus       159-bit decode bundle
//   ex_to_mem_bus      76-bit bundle to the memory stage
//   ex_to_rf_bus       {rf_we, rf_waddr, ex_result} forwarded to decode
//   ex_is_load         EX holds a load (load-use hazard detection)
//   stallreq_for_ex    divider stall request
//   data_sram_*        data SRAM request (en, wen, addr, wdata)
//   hi_o, lo_o         HI/LO registers written by div/divu
module ex_stage #(
  parameter int DIV_ITERS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         ex_is_load,
  output logic         stallreq_for_ex,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [31:0]  hi_o,
  output logic [31:0]  lo_o
);

  localparam int CW = $clog2(DIV_ITERS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic [158:0] ex_reg;

  // ID/EX register: bubble when ID/EX stops but EX/MEM advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_reg <= '0;
    end else if (stall[2] && !stall[3]) begin
      ex_reg <= '0;
    end else if (!stall[2]) begin
      ex_reg <= id_to_ex_bus;
    end
  end

  logic [31:0] pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign pc         = ex_reg[158:127];
  assign inst       = ex_reg[126:95];
  assign alu_op     = ex_reg[94:83];
  assign sel_src1   = ex_reg[82:80];
  assign sel_src2   = ex_reg[79:76];
  assign ram_en     = ex_reg[75];
  assign ram_wen    = ex_reg[74:71];
  assign rf_we      = ex_reg[70];
  assign rf_waddr   = ex_reg[69:65];
  assign sel_rf_res = ex_reg[64];
  assign rs_data    = ex_reg[63:32];
  assign rt_data    = ex_reg[31:0];

  // Operand selection as AND-OR of one-hot selects; all-zero select yields 0.
  logic [31:0] src1, src2;
  assign src1 = ({32{sel_src1[0]}} & rs_data)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rt_data)
              | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

  logic [31:0] add_res, sub_res, slt_res, sltu_res, sra_res, ex_result;
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'b0, src1 < src2};
  assign sra_res  = $signed(src2) >>> src1[4:0];

  assign ex_result = ({32{alu_op[11]}} & add_res)
                   | ({32{alu_op[10]}} & sub_res)
                   | ({32{alu_op[9]}}  & slt_res)
                   | ({32{alu_op[8]}}  & sltu_res)
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                   | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                   | ({32{alu_op[1]}}  & sra_res)
                   | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};
  assign ex_is_load    = sel_rf_res;

  // Divider
  logic is_div, div_signed;
  assign is_div     = (inst[31:26] == 6'b0) && ((inst[5:0] == 6'h1A) || (inst[5:0] == 6'h1B));
  assign div_signed = ~inst[0];

  div_state_t state, state_next;
  logic [31:0] dvd, dvs, rem, rs_raw, hi_q, lo_q;
  logic [CW-1:0] cnt;
  logic q_neg, r_neg, div_zero;
  logic last_step;

  assign last_step = (cnt == CW'(DIV_ITERS - 1));

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [32:0] trial, diff;
  logic        qbit;
  logic [31:0] rem_step, dvd_step, q_fix, r_fix;
  assign trial    = {rem, dvd[31]};
  assign diff     = trial - {1'b0, dvs};
  assign qbit     = ~diff[32];
  assign rem_step = qbit ? diff[31:0] : trial[31:0];
  assign dvd_step = {dvd[30:0], qbit};
  assign q_fix    = q_neg ? (32'd0 - dvd_step) : dvd_step;
  assign r_fix    = r_neg ? (32'd0 - rem_step) : rem_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (is_div) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (!stall[2]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      rs_raw   <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            dvd      <= (div_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
            dvs      <= (div_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
            rem      <= '0;
            rs_raw   <= rs_data;
            cnt      <= '0;
            q_neg    <= div_signed & (rs_data[31] ^ rt_data[31]);
            r_neg    <= div_signed & rs_data[31];
            div_zero <= (rt_data == 32'd0);
          end
        end
        BUSY: begin
          dvd <= dvd_step;
          rem <= rem_step;
          cnt <= cnt + CW'(1);
          // The final step's result is written straight into HI/LO on the edge entering DONE.
          if (last_step) begin
            if (div_zero) begin
              hi_q <= rs_raw;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stallreq_for_ex = ((state == IDLE) && is_div) || (state == BUSY);
  assign hi_o = hi_q;
  assign lo_o = lo_q;

  assign data_sram_en    = ram_en & ~stallreq_for_ex;
  assign data_sram_wen   = (ram_en && (ram_wen != 4'b0) && !stallreq_for_ex) ? 4'b1111 : 4'b0000;
  assign data_sram_addr  = stallreq_for_ex ? 32'd0 : ex_result;
  assign data_sram_wdata = stallreq_for_ex ? 32'd0 : rt_data;

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of instruction decode. Each clock it latches the 159-bit decode bundle, computes the ALU result, and issues the data-SRAM request. It also drives the EX forwarding bus back to decode and runs a 32-iteration divider for `div`/`divu`, which writes HI/LO and stalls the pipeline while busy.

## Interface
- `DIV_ITERS`, default 32: divider iteration count; one quotient bit per cycle.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `stall`  in  `StallBus`  stall vector; `Stop` = 1. Bit 2 = ID/EX register, bit 3 = EX/MEM register.
- `id_to_ex_bus`  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_data[63:32], rt_data[31:0]}.
- `ex_to_mem_bus`  out  76  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- `ex_to_rf_bus`  out  38  {rf_we, rf_waddr, ex_result}; forwarding to decode.
- `ex_is_load`  out  1  EX holds a load (sel_rf_res=1); decode uses it for the load-use stall.
- `stallreq_for_ex`  out  1  divider stall request.
- `data_sram_en`  out  1  data SRAM enable.
- `data_sram_wen`  out  4  byte write enables.
- `data_sram_addr`  out  32  byte address.
- `data_sram_wdata`  out  32  store data.
- `hi_o`  out  32  HI register.
- `lo_o`  out  32  LO register.

## Operation
- **ID/EX register update** (first matching rule wins):
  - rst=0: clear to 0.
  - stall[2]=Stop and stall[3]=NoStop: load all-zero (bubble).
  - stall[2]=NoStop: load `id_to_ex_bus`.
  - Otherwise: hold.
- **src1 selection** (one-hot; all zero gives 0): [0] rs_data, [1] pc, [2] {27'b0, inst[10:6]}.
- **src2 selection**: [0] rt_data, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0].
- **alu_op**, bit 11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui. Results:
  - add/sub: modulo 2^32.
  - slt: signed compare → 0/1. sltu: unsigned compare → 0/1.
  - sll/srl/sra: shift src2 by src1[4:0].
  - lui: {src2[15:0], 16'b0}.
  - All-zero alu_op gives result 0. No overflow trap.
- **Memory request**:
  - data_sram_en = ram_en.
  - data_sram_addr = ex_result.
  - data_sram_wdata = rt_data.
  - data_sram_wen = 4'b1111 when ram_en and ram_wen≠0, else 4'b0000.
  - All four signals are forced to 0 while stallreq_for_ex=1.
- **Divider trigger**: inst[31:26]=0 and inst[5:0] = 6'h1A (div, signed) or 6'h1B (divu).
- **Divider FSM**:
  - IDLE: a div in EX moves to BUSY. Latch |rs| and |rt| (raw values for divu), the quotient sign (rs[31]^rt[31]) and the remainder sign (rs[31]); clear the counter.
  - BUSY: restoring step, one quotient bit per cycle. After DIV_ITERS steps, go to DONE.
  - DONE: on entry, apply sign fix-up and write HI=remainder, LO=quotient. Go to IDLE when stall[2]=NoStop; otherwise stay in DONE without re-triggering.
- **Divide by zero**: LO=32'hFFFFFFFF, HI=rs_data, for both div and divu. Takes the same latency as a normal divide.
- **stallreq_for_ex** = (IDLE and div in EX) or BUSY. It is combinational from state and the ID/EX register.
- **Forwarding outputs**: ex_to_rf_bus and ex_is_load reflect the ID/EX register contents; a bubble gives rf_we=0.

## Timing
- ALU, memory request and forwarding buses are combinational from the ID/EX register: zero-cycle latency after the clock edge.
- **Division**: div enters EX at edge E0.
  - stallreq_for_ex is high from E0 through the end of the 32nd BUSY cycle.
  - HI/LO are updated at the edge that enters DONE (E0+33).
  - stallreq_for_ex is low in the DONE cycle, so the pipeline advances at E0+34.
- **Reset values**: all outputs 0, HI=LO=0, FSM=IDLE. Reset mid-division aborts it; HI/LO return to 0.
- A bubble loaded during BUSY cannot occur, because stall[2] is held Stop by stallreq_for_ex. Any other stall source during BUSY holds the register and does not disturb the FSM.
- Two back-to-back divs: the second starts only after the FSM returns to IDLE. Its stall begins the cycle it is in EX.

## Test plan
- **addu**: rs=32'h7FFFFFFF, rt=1, alu_op add, src1=rs, src2=rt → ex_result=32'h80000000; ex_to_rf_bus={1, rd, 32'h80000000}; no stall.
- **jal**: pc=32'hBFC00010, src1=pc, src2=8 → ex_result=32'hBFC00018, waddr=31.
- **sw**: rs=32'h1000, imm=16'hFFFC, rt=32'hDEADBEEF → data_sram_en=1, wen=4'b1111, addr=32'h0FFC, wdata=32'hDEADBEEF.
- **div** rs=-7, rt=2 → stallreq_for_ex high for exactly 33 cycles; then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. **divu** rs=7, rt=0 → LO=32'hFFFFFFFF, HI=7.
- **Stall bubble**: stall[2]=1, stall[3]=0 → next cycle all outputs 0. stall[2]=stall[3]=1 → register held for the stall duration.
- **Reset**: assert rst=0 at BUSY cycle 10 → stallreq_for_ex and HI/LO=0 immediately; after release, a fresh div completes normally.
